// File: rtl/minimig_clk_pkg.sv
// Shared types and constants for the Minimig clock/reset sequencer.
package minimig_clk_pkg;

   // Sequencer states; the encoding is exported on seq_state for debug LEDs
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   // Bus phase on which the 7 MHz rising-phase enable fires
   localparam logic [3:0] PH_CE7    = 4'd0;
   // Bus phase on which the 7 MHz falling-phase enable fires
   localparam logic [3:0] PH_CE7N   = 4'd8;
   // Low phase bits that must all be zero for a 28 MHz enable
   localparam logic [1:0] CE28_MASK = 2'b11;

   // Larger of two integers, used to size the shared interval counter
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync2_ff.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
// Used for any single-bit or independent multi-bit CDC crossing.
module sync2_ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   // Two back-to-back flops give metastability one full cycle to settle
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/minimig_clkrst_seq.sv
// Reset sequencer and 28/7 MHz clock-enable generator for the system clock.
// Filters PLL lock, holds the system in reset for a programmed interval and
// releases sys_rst_n exactly on bus phase 0 so the chipset starts aligned.
module minimig_clkrst_seq
   import minimig_clk_pkg::*;
#(
   parameter int LOCK_FILT = 1024,
   parameter int RST_HOLD  = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       sw_reset_req,
   output logic       sys_rst_n,
   output logic       ce_28,
   output logic       ce_7,
   output logic       ce_7n,
   output logic [3:0] phase,
   output logic [1:0] seq_state
);

   localparam int CNT_W = $clog2(max_int(LOCK_FILT, RST_HOLD));
   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

   logic             lock_s;
   seq_state_t       state_reg,  state_next;
   logic [CNT_W-1:0] cnt_reg,    cnt_next;
   logic [3:0]       phase_reg,  phase_next;
   logic             srst_n_reg, srst_n_next;
   logic             ce_28_reg,  ce_28_next;
   logic             ce_7_reg,   ce_7_next;
   logic             ce_7n_reg,  ce_7n_next;
   logic             ce_active;

   sync2_ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk   (clk),
      .clr_n (rst_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   // Next-state, interval counter and bus phase; lock loss always has priority
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      phase_next = phase_reg;
      unique case (state_reg)
         WAIT_LOCK: begin
            cnt_next   = '0;
            phase_next = '0;
            if (lock_s) begin
               state_next = FILTER;
            end
         end
         FILTER: begin
            phase_next = '0;
            if (!lock_s) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt_reg == FILT_LAST) begin
               state_next = HOLD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         HOLD: begin
            phase_next = phase_reg + 4'd1;
            if (!lock_s) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
               phase_next = '0;
            end else if (cnt_reg == HOLD_LAST) begin
               // Release only at the end of a bus cycle so RUN starts on phase 0
               if (phase_reg == 4'd15) begin
                  state_next = RUN;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RUN: begin
            phase_next = phase_reg + 4'd1;
            if (!lock_s) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
               phase_next = '0;
            end else if (sw_reset_req) begin
               // Soft reset keeps the phase running so the enables never glitch
               state_next = HOLD;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
            phase_next = '0;
         end
      endcase
   end

   // Decode enables and reset from next-cycle values so the registered outputs line up with phase
   always_comb begin
      ce_active   = (state_next == HOLD) || (state_next == RUN);
      ce_28_next  = ce_active && ((phase_next[1:0] & CE28_MASK) == 2'b00);
      ce_7_next   = ce_active && (phase_next == PH_CE7);
      ce_7n_next  = ce_active && (phase_next == PH_CE7N);
      srst_n_next = (state_next == RUN);
   end

   // Sequencer state, counter and phase registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= WAIT_LOCK;
         cnt_reg   <= '0;
         phase_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         phase_reg <= phase_next;
      end
   end

   // Registered reset and enable outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         srst_n_reg <= 1'b0;
         ce_28_reg  <= 1'b0;
         ce_7_reg   <= 1'b0;
         ce_7n_reg  <= 1'b0;
      end else begin
         srst_n_reg <= srst_n_next;
         ce_28_reg  <= ce_28_next;
         ce_7_reg   <= ce_7_next;
         ce_7n_reg  <= ce_7n_next;
      end
   end

   assign sys_rst_n = srst_n_reg;
   assign ce_28     = ce_28_reg;
   assign ce_7      = ce_7_reg;
   assign ce_7n     = ce_7n_reg;
   assign phase     = phase_reg;
   assign seq_state = state_reg;

endmodule

// File: tb/tb_minimig_clkrst_seq.sv
// Self-checking bench for minimig_clkrst_seq (LOCK_FILT=8, RST_HOLD=32).
// Expected reset edges are predicted from the timing rules and queued; a
// negedge monitor pops them when sys_rst_n actually moves, and checks phase
// and enables against the phase reference of the last lock-based release.
`timescale 1ns/1ps
module tb_minimig_clkrst_seq;

   localparam int LF       = 8;
   localparam int RH       = 32;
   // HOLD entered at phase 0 lasts the first multiple of 16 that is >= RH
   localparam int HOLD_LEN = ((RH + 15) / 16) * 16;
   // pll_locked change -> FILTER takes 3 edges (2 sync + state register)
   localparam int SEQ_LAT  = 3 + LF + HOLD_LEN;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       pll_locked = 1'b0;
   logic       sw_reset_req = 1'b0;
   logic       sys_rst_n;
   logic       ce_28;
   logic       ce_7;
   logic       ce_7n;
   logic [3:0] phase;
   logic [1:0] seq_state;

   minimig_clkrst_seq #(
      .LOCK_FILT (LF),
      .RST_HOLD  (RH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .sw_reset_req (sw_reset_req),
      .sys_rst_n    (sys_rst_n),
      .ce_28        (ce_28),
      .ce_7         (ce_7),
      .ce_7n        (ce_7n),
      .phase        (phase),
      .seq_state    (seq_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   int exp_rise_q[$];
   int exp_fall_q[$];

   bit   ce_chk   = 1'b0;
   bit   cnt_en   = 1'b0;
   int   ref_base = 0;
   int   n28 = 0, n7 = 0, n7n = 0;
   logic prev_srst  = 1'b0;
   bit   prev_valid = 1'b0;
   int   mon_e, mon_pe, mon_exp, mon_got;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
   endtask

   // Monitor: pop expected reset edges when they occur, check phase/enables each cycle
   always @(negedge clk) begin
      if (rst_n && prev_valid && sys_rst_n && !prev_srst) begin
         if (exp_rise_q.size() == 0) chk("unexpected_rise", cyc, -1);
         else begin
            mon_e = exp_rise_q.pop_front();
            chk("rise_cycle", cyc, mon_e);
            chk("rise_phase", int'(phase), 0);
            chk("rise_ce7", int'(ce_7), 1);
            chk("rise_ce28", int'(ce_28), 1);
         end
      end
      if (rst_n && prev_valid && !sys_rst_n && prev_srst) begin
         if (exp_fall_q.size() == 0) chk("unexpected_fall", cyc, -1);
         else begin
            mon_e = exp_fall_q.pop_front();
            chk("fall_cycle", cyc, mon_e);
         end
      end
      if (rst_n && ce_chk) begin
         mon_pe  = ((cyc - ref_base) % 16 + 16) % 16;
         mon_exp = mon_pe * 8 + ((mon_pe % 4 == 0) ? 4 : 0)
                   + ((mon_pe == 0) ? 2 : 0) + ((mon_pe == 8) ? 1 : 0);
         mon_got = int'(phase) * 8 + int'(ce_28) * 4 + int'(ce_7) * 2 + int'(ce_7n);
         chk("phase_ce", mon_got, mon_exp);
      end
      if (cnt_en) begin
         n28 += int'(ce_28);
         n7  += int'(ce_7);
         n7n += int'(ce_7n);
      end
      prev_srst  = sys_rst_n;
      prev_valid = rst_n;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
      chk({tag, "_ce_28"}, int'(ce_28), 0);
      chk({tag, "_ce_7"}, int'(ce_7), 0);
      chk({tag, "_ce_7n"}, int'(ce_7n), 0);
      chk({tag, "_phase"}, int'(phase), 0);
      chk({tag, "_seq_state"}, int'(seq_state), 0);
   endtask

   // Full lock sequence after pll_locked (held high) is first seen at cycle k0
   task automatic lock_sequence(input int k0, output int rise);
      rise = k0 + SEQ_LAT;
      exp_rise_q.push_back(rise);
      ref_base = rise;
      wait_until(k0 + 2);
      chk("st_wait", int'(seq_state), 0);
      wait_until(k0 + 3);
      chk("st_filter_first", int'(seq_state), 1);
      wait_until(k0 + 2 + LF);
      chk("st_filter_last", int'(seq_state), 1);
      wait_until(k0 + 3 + LF);
      chk("st_hold_first", int'(seq_state), 2);
      ce_chk = 1'b1;
      wait_until(rise - 1);
      chk("st_hold_last", int'(seq_state), 2);
      chk("srst_before_rise", int'(sys_rst_n), 0);
      wait_until(rise);
      chk("st_run", int'(seq_state), 3);
   endtask

   initial begin
      int rise, s, c, n, k, j, a;

      // Scenario 1: reset, lock held high from release
      #2 rst_n = 1'b0;
      pll_locked = 1'b1;
      #1;
      check_reset_outputs("por");
      repeat (3) tick();
      rst_n = 1'b1;
      lock_sequence(cyc, rise);

      // Scenario 5: 160-cycle free run in RUN
      a = rise + int'($urandom_range(1, 15));
      wait_until(a);
      n28 = 0; n7 = 0; n7n = 0;
      cnt_en = 1'b1;
      wait_until(a + 160);
      cnt_en = 1'b0;
      chk("count_ce28", n28, 40);
      chk("count_ce7", n7, 10);
      chk("count_ce7n", n7n, 10);

      // Scenario 4: soft reset at random phases; a second pulse inside HOLD is ignored
      for (int it = 0; it < 3; it++) begin
         s = cyc + int'($urandom_range(3, 40));
         wait_until(s);
         sw_reset_req = 1'b1;
         tick();
         sw_reset_req = 1'b0;
         exp_fall_q.push_back(s + 1);
         c = s + 1 + RH;
         while (((c - ref_base) % 16 + 16) % 16 != 0) c++;
         exp_rise_q.push_back(c);
         chk("sw_hold_state", int'(seq_state), 2);
         wait_until(s + 1 + int'($urandom_range(2, 25)));
         sw_reset_req = 1'b1;
         tick();
         sw_reset_req = 1'b0;
         wait_until(c);
         chk("sw_run_state", int'(seq_state), 3);
         tick();
      end

      // Scenario 3: lock loss in RUN, with a simultaneous soft reset that must lose
      n = cyc + int'($urandom_range(2, 20));
      wait_until(n);
      ce_chk = 1'b0;
      pll_locked = 1'b0;
      exp_fall_q.push_back(n + 3);
      wait_until(n + 2);
      chk("lockloss_srst_still_high", int'(sys_rst_n), 1);
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      chk("lockloss_sys_rst_n", int'(sys_rst_n), 0);
      chk("lockloss_ce_28", int'(ce_28), 0);
      chk("lockloss_ce_7", int'(ce_7), 0);
      chk("lockloss_ce_7n", int'(ce_7n), 0);
      chk("lockloss_state", int'(seq_state), 0);
      wait_until(n + 12);
      chk("lockloss_stay_wait", int'(seq_state), 0);
      chk("lockloss_phase", int'(phase), 0);

      // Scenario 2: one-cycle lock glitch during FILTER restarts filtering
      k = cyc;
      pll_locked = 1'b1;
      j = int'($urandom_range(3, LF - 1));
      wait_until(k + 3);
      chk("glitch_filter_entered", int'(seq_state), 1);
      wait_until(k + j);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      lock_sequence(cyc, rise);

      // Scenario 6: asynchronous reset mid-HOLD, then full sequence again
      s = cyc + int'($urandom_range(2, 10));
      wait_until(s);
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      exp_fall_q.push_back(s + 1);
      wait_until(s + 1 + int'($urandom_range(2, 20)));
      chk("midhold_state", int'(seq_state), 2);
      ce_chk = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midhold_rst");
      repeat (3) tick();
      rst_n = 1'b1;
      lock_sequence(cyc, rise);
      wait_until(rise + 20);

      chk("rise_queue_empty", exp_rise_q.size(), 0);
      chk("fall_queue_empty", exp_fall_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
